// File: rtl/if_prefetch_unit.sv
// Instruction fetch stage with a credit-based prefetch queue, redirect flush and sticky halt.
// Optional perf counters are built when IF_PERF_EN is defined.
module if_prefetch_unit #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 10,
  parameter int          Q_DEPTH  = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk1,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_ir,
  output logic [ADDR_W-1:0] if_id_npc,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              taken_branch,
  input  logic              halt_req,
  output logic              halted
`ifdef IF_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_addr;
  logic              inflight;
  logic [DATA_W-1:0] q_ir  [Q_DEPTH];
  logic [ADDR_W-1:0] q_npc [Q_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credits;
  logic              running;
  logic              flush;
  logic              issue;
  logic              push;
  logic              pop;

  assign running = (state == RUN);
  assign flush   = running & redirect_valid;
  assign credits = {1'b0, count} + (CNT_W+1)'(inflight);

  // Gated by rst_n so the request line stays low while reset is held.
  assign issue = rst_n & running & !halt_req & !redirect_valid
               & (credits < (CNT_W+1)'(Q_DEPTH));
  assign push  = inflight & !flush;
  assign pop   = if_id_valid & id_ready & !flush;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      running && halt_req: state_nxt = HALT;
      default:             state_nxt = state;
    endcase
  end

  always_comb begin
    halted    = (state == HALT);
    imem_req  = issue;
    imem_addr = fetch_pc;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc      <= ADDR_W'(RESET_PC);
      inflight      <= 1'b0;
      inflight_addr <= '0;
      taken_branch  <= 1'b0;
    end else begin
      inflight     <= issue;
      taken_branch <= flush;
      if (issue) inflight_addr <= fetch_pc;
      if (flush)      fetch_pc <= redirect_pc;
      else if (issue) fetch_pc <= fetch_pc + 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < Q_DEPTH; i++) begin
        q_ir[i]  <= '0;
        q_npc[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_ir[wr_ptr]  <= imem_rdata;
        q_npc[wr_ptr] <= inflight_addr + 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign if_id_valid = (count != '0);
  assign if_id_ir    = q_ir[rd_ptr];
  assign if_id_npc   = q_npc[rd_ptr];

  // Credits cap count+inflight at Q_DEPTH, so a push never meets a full queue.
  a_no_overflow: assert property (@(posedge clk1) disable iff (!rst_n)
    !(push && count == CNT_W'(Q_DEPTH)));

`ifdef IF_PERF_EN
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push && perf_fetch_cnt != '1)
        perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (flush && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit; memory returns its own word address.
// Build with IF_PERF_EN defined to also exercise the perf counters.
module tb_if_prefetch_unit;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        if_id_valid;
  logic [31:0] if_id_ir;
  logic [9:0]  if_id_npc;
  logic        id_ready;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        taken_branch;
  logic        halt_req;
  logic        halted;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  if_prefetch_unit dut (
    .clk1           (clk1),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_ir       (if_id_ir),
    .if_id_npc      (if_id_npc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .taken_branch   (taken_branch),
    .halt_req       (halt_req),
    .halted         (halted)
`ifdef IF_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk1 = ~clk1;

  // Synchronous memory model: Mem[i] = i.
  always @(posedge clk1) imem_rdata <= {22'h0, imem_addr};

  task automatic tick;
    @(posedge clk1);
    #2;
  endtask

  task automatic do_reset;
    rst_n          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if ({imem_req, imem_addr, if_id_valid} !== 12'h0) begin
      errors++;
      $display("FAIL reset_fetch got req=%b addr=%h valid=%b exp 0",
               imem_req, imem_addr, if_id_valid);
    end
    checks++;
    if ({if_id_ir, if_id_npc} !== 42'h0) begin
      errors++;
      $display("FAIL reset_head got ir=%h npc=%h exp 0", if_id_ir, if_id_npc);
    end
    checks++;
    if ({taken_branch, halted} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got tb=%b halted=%b exp 0",
               taken_branch, halted);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 10'h000}) begin
      errors++;
      $display("FAIL reset_first_req got req=%b addr=%h exp 1/000",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_stream;
    do_reset();
    id_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 10'(c)}) begin
        errors++;
        $display("FAIL stream_req c=%0d got req=%b addr=%h exp 1/%h",
                 c, imem_req, imem_addr, 10'(c));
      end
      checks++;
      if (c < 2) begin
        if (if_id_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_early c=%0d got valid=%b exp 0", c, if_id_valid);
        end
      end else if ({if_id_valid, if_id_ir, if_id_npc} !==
                   {1'b1, 32'(c - 2), 10'(c - 1)}) begin
        errors++;
        $display("FAIL stream_head c=%0d got v=%b ir=%h npc=%h exp 1/%h/%h",
                 c, if_id_valid, if_id_ir, if_id_npc, 32'(c - 2), 10'(c - 1));
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    int nreq;
    logic [31:0] exp;
    nreq = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #1;
      if (imem_req) nreq++;
      if (c == 9) begin
        checks++;
        if ({if_id_valid, if_id_ir, imem_addr} !== {1'b1, 32'h0, 10'h004}) begin
          errors++;
          $display("FAIL bp_full got v=%b ir=%h addr=%h exp 1/0/004",
                   if_id_valid, if_id_ir, imem_addr);
        end
      end
      tick();
    end
    checks++;
    if (nreq !== 4) begin
      errors++;
      $display("FAIL bp_req_count got %0d exp 4", nreq);
    end
    id_ready = 1'b1;
    exp = 0;
    for (int c = 10; c < 22; c++) begin
      #1;
      checks++;
      if ({if_id_valid, if_id_ir, if_id_npc} !== {1'b1, exp, 10'(exp + 1)}) begin
        errors++;
        $display("FAIL bp_drain c=%0d got v=%b ir=%h npc=%h exp 1/%h/%h",
                 c, if_id_valid, if_id_ir, if_id_npc, exp, 10'(exp + 1));
      end
      exp++;
      tick();
    end
  endtask

  task automatic test_redirect;
    do_reset();
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h100;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_noissue got req=%b exp 0", imem_req);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({if_id_valid, taken_branch, imem_req, imem_addr} !==
        {3'b011, 10'h100}) begin
      errors++;
      $display("FAIL redir_t1 got v=%b tb=%b req=%b addr=%h exp 0/1/1/100",
               if_id_valid, taken_branch, imem_req, imem_addr);
    end
    tick();
    #1;
    checks++;
    if ({if_id_valid, taken_branch, imem_req, imem_addr} !==
        {3'b001, 10'h101}) begin
      errors++;
      $display("FAIL redir_t2 got v=%b tb=%b req=%b addr=%h exp 0/0/1/101",
               if_id_valid, taken_branch, imem_req, imem_addr);
    end
    tick();
    #1;
    checks++;
    if ({if_id_valid, if_id_ir, if_id_npc} !== {1'b1, 32'h100, 10'h101}) begin
      errors++;
      $display("FAIL redir_t3 got v=%b ir=%h npc=%h exp 1/100/101",
               if_id_valid, if_id_ir, if_id_npc);
    end
    id_ready = 1'b1;
    tick();
    #1;
    checks++;
    if ({if_id_valid, if_id_ir, if_id_npc} !== {1'b1, 32'h101, 10'h102}) begin
      errors++;
      $display("FAIL redir_t4 got v=%b ir=%h npc=%h exp 1/101/102",
               if_id_valid, if_id_ir, if_id_npc);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    id_ready = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h200;
    tick();
    redirect_pc = 10'h300;
    #1;
    checks++;
    if ({imem_req, taken_branch} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_second got req=%b tb=%b exp 0/1", imem_req, taken_branch);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({if_id_valid, taken_branch, imem_req, imem_addr} !==
        {3'b011, 10'h300}) begin
      errors++;
      $display("FAIL b2b_req got v=%b tb=%b req=%b addr=%h exp 0/1/1/300",
               if_id_valid, taken_branch, imem_req, imem_addr);
    end
    tick();
    #1;
    checks++;
    if ({if_id_valid, taken_branch} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_gap got v=%b tb=%b exp 0/0", if_id_valid, taken_branch);
    end
    tick();
    #1;
    checks++;
    if ({if_id_valid, if_id_ir, if_id_npc} !== {1'b1, 32'h300, 10'h301}) begin
      errors++;
      $display("FAIL b2b_head got v=%b ir=%h npc=%h exp 1/300/301",
               if_id_valid, if_id_ir, if_id_npc);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    id_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3FE;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 10'h3FE) begin
      errors++;
      $display("FAIL wrap_a0 got addr=%h exp 3fe", imem_addr);
    end
    tick();
    #1;
    checks++;
    if (imem_addr !== 10'h3FF) begin
      errors++;
      $display("FAIL wrap_a1 got addr=%h exp 3ff", imem_addr);
    end
    tick();
    #1;
    checks++;
    if ({imem_req, imem_addr, if_id_ir, if_id_npc} !==
        {1'b1, 10'h000, 32'h3FE, 10'h3FF}) begin
      errors++;
      $display("FAIL wrap_a2 got req=%b addr=%h ir=%h npc=%h exp 1/000/3fe/3ff",
               imem_req, imem_addr, if_id_ir, if_id_npc);
    end
    tick();
    #1;
    checks++;
    if ({if_id_valid, if_id_ir, if_id_npc} !== {1'b1, 32'h3FF, 10'h000}) begin
      errors++;
      $display("FAIL wrap_npc got v=%b ir=%h npc=%h exp 1/3ff/000",
               if_id_valid, if_id_ir, if_id_npc);
    end
    tick();
    #1;
    checks++;
    if ({if_id_valid, if_id_ir, if_id_npc} !== {1'b1, 32'h000, 10'h001}) begin
      errors++;
      $display("FAIL wrap_after got v=%b ir=%h npc=%h exp 1/000/001",
               if_id_valid, if_id_ir, if_id_npc);
    end
  endtask

  task automatic test_halt;
    do_reset();
    tick();
    halt_req = 1'b1;
    #1;
    checks++;
    if ({imem_req, halted} !== 2'b00) begin
      errors++;
      $display("FAIL halt_req_cycle got req=%b halted=%b exp 0/0", imem_req, halted);
    end
    tick();
    halt_req = 1'b0;
    #1;
    checks++;
    if ({halted, imem_req, if_id_valid, if_id_ir} !== {3'b101, 32'h0}) begin
      errors++;
      $display("FAIL halt_deliver got h=%b req=%b v=%b ir=%h exp 1/0/1/0",
               halted, imem_req, if_id_valid, if_id_ir);
    end
    id_ready = 1'b1;
    tick();
    #1;
    checks++;
    if ({if_id_valid, imem_req} !== 2'b00) begin
      errors++;
      $display("FAIL halt_drain got v=%b req=%b exp 0/0", if_id_valid, imem_req);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 10'h055;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({taken_branch, imem_req, halted, imem_addr} !== {3'b001, 10'h001}) begin
      errors++;
      $display("FAIL halt_redirect got tb=%b req=%b h=%b addr=%h exp 0/0/1/001",
               taken_branch, imem_req, halted, imem_addr);
    end
  endtask

  task automatic test_redirect_halt;
    do_reset();
    id_ready = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h080;
    halt_req       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    #1;
    checks++;
    if ({taken_branch, halted, if_id_valid, imem_req} !== 4'b1100) begin
      errors++;
      $display("FAIL rh_t1 got tb=%b h=%b v=%b req=%b exp 1/1/0/0",
               taken_branch, halted, if_id_valid, imem_req);
    end
    tick();
    #1;
    checks++;
    if ({taken_branch, if_id_valid, imem_req} !== 3'b000) begin
      errors++;
      $display("FAIL rh_t2 got tb=%b v=%b req=%b exp 0/0/0",
               taken_branch, if_id_valid, imem_req);
    end
  endtask

`ifdef IF_PERF_EN
  task automatic test_perf;
    do_reset();
    id_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      redirect_valid = (c == 10 || c == 21);
      redirect_pc    = 10'h040;
      tick();
    end
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({perf_fetch_cnt, perf_flush_cnt} !== {32'd18, 16'd2}) begin
      errors++;
      $display("FAIL perf_cnt got fetch=%0d flush=%0d exp 18/2",
               perf_fetch_cnt, perf_flush_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_halt();
    test_redirect_halt();
`ifdef IF_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
